// File: rtl/competition_ctrl.sv
// Quiz round controller: conditions the host and player buttons and runs the
// idle / armed-countdown / winner / foul / timeout sequence behind the display.
module competition_ctrl #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int TICK_CYCLES = 100_000_000,
    parameter int BUZZ_CYCLES = 20_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic [7:0] player_btn,
    output logic [2:0] view,
    output logic [3:0] state,
    output logic [7:0] led,
    output logic       buzzer
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int BUZZ_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_CYCLES - 1);

    // State encoding doubles as the view code, so view comes straight from the register.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WIN     = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_FOUL    = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    logic [8:0]      btnPins;
    logic [8:0]      sync1_q;
    logic [8:0]      sync2_q;
    logic [8:0]      level_q;
    logic [8:0]      levelPrev_q;
    logic [8:0]      press;
    logic [DB_W-1:0] dbCnt_q [9];

    logic [7:0] playerPress;
    logic       startPress;
    logic       anyPlayer;
    logic [2:0] winnerIdx;
    logic [3:0] winnerNum;
    logic [7:0] winnerLed;

    logic [2:0]        fsm_q,     fsm_d;
    logic [3:0]        count_q,   count_d;
    logic [7:0]        led_q,     led_d;
    logic              buzzer_q,  buzzer_d;
    logic [BUZZ_W-1:0] buzzCnt_q, buzzCnt_d;
    logic [TICK_W-1:0] tick_q,    tick_d;

    assign btnPins = {start_btn, player_btn};

    // Debounced level flips only once the counter has already reached DB_CYCLES
    // on a still-mismatching cycle, giving the pin-to-level latency of DB_CYCLES+2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            levelPrev_q <= '0;
            for (int i = 0; i < 9; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= btnPins;
            sync2_q     <= sync1_q;
            levelPrev_q <= level_q;
            for (int i = 0; i < 9; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (dbCnt_q[i] == DB_LAST) begin
                        level_q[i] <= sync2_q[i];
                        dbCnt_q[i] <= '0;
                    end else begin
                        dbCnt_q[i] <= dbCnt_q[i] + DB_W'(1);
                    end
                end else begin
                    dbCnt_q[i] <= '0;
                end
            end
        end
    end

    assign press       = level_q & ~levelPrev_q;
    assign playerPress = press[7:0];
    assign startPress  = press[8];
    assign anyPlayer   = |playerPress;

    // Scanning downward leaves the lowest pressed index as the winner.
    always_comb begin
        winnerIdx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (playerPress[i]) begin
                winnerIdx = 3'(i);
            end
        end
    end

    assign winnerNum = {1'b0, winnerIdx} + 4'd1;
    assign winnerLed = 8'd1 << winnerIdx;

    always_comb begin
        fsm_d     = fsm_q;
        count_d   = count_q;
        led_d     = led_q;
        buzzer_d  = buzzer_q;
        buzzCnt_d = buzzCnt_q;
        tick_d    = tick_q;
        case (fsm_q)
            S_IDLE: begin
                if (anyPlayer) begin
                    fsm_d     = S_FOUL;
                    count_d   = winnerNum;
                    led_d     = winnerLed;
                    buzzer_d  = 1'b1;
                    buzzCnt_d = BUZZ_LOAD;
                end else if (startPress) begin
                    fsm_d   = S_ARMED;
                    count_d = 4'd9;
                    tick_d  = '0;
                end
            end
            S_ARMED: begin
                if (anyPlayer) begin
                    fsm_d     = S_WIN;
                    count_d   = winnerNum;
                    led_d     = winnerLed;
                    buzzer_d  = 1'b1;
                    buzzCnt_d = BUZZ_LOAD;
                    tick_d    = '0;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (count_q != 4'd0) begin
                        count_d = count_q - 4'd1;
                    end else begin
                        fsm_d = S_TIMEOUT;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_WIN, S_FOUL: begin
                if (startPress) begin
                    fsm_d     = S_IDLE;
                    count_d   = 4'd0;
                    led_d     = 8'd0;
                    buzzer_d  = 1'b0;
                    buzzCnt_d = '0;
                end else if (buzzCnt_q != '0) begin
                    buzzCnt_d = buzzCnt_q - BUZZ_W'(1);
                end else begin
                    buzzer_d = 1'b0;
                end
            end
            S_TIMEOUT: begin
                if (startPress) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d     = S_IDLE;
                count_d   = 4'd0;
                led_d     = 8'd0;
                buzzer_d  = 1'b0;
                buzzCnt_d = '0;
                tick_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q     <= S_IDLE;
            count_q   <= 4'd0;
            led_q     <= 8'd0;
            buzzer_q  <= 1'b0;
            buzzCnt_q <= '0;
            tick_q    <= '0;
        end else begin
            fsm_q     <= fsm_d;
            count_q   <= count_d;
            led_q     <= led_d;
            buzzer_q  <= buzzer_d;
            buzzCnt_q <= buzzCnt_d;
            tick_q    <= tick_d;
        end
    end

    assign view   = fsm_q;
    assign state  = count_q;
    assign led    = led_q;
    assign buzzer = buzzer_q;

endmodule

// File: tb/tb_competition_ctrl.sv
// Bench for competition_ctrl: directed round scenarios followed by random button
// activity, every cycle compared against a sliding-window / elapsed-time model.
module tb_competition_ctrl;

    localparam int DB   = 4;
    localparam int TICK = 16;
    localparam int BUZZ = 8;
    localparam int HL   = DB + 3;

    localparam int P_IDLE    = 0;
    localparam int P_WIN     = 1;
    localparam int P_ARMED   = 2;
    localparam int P_FOUL    = 3;
    localparam int P_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic [7:0] player_btn;
    logic [2:0] view;
    logic [3:0] state;
    logic [7:0] led;
    logic       buzzer;

    int checkCount = 0;
    int passCount  = 0;
    int buzzCount  = 0;

    int phase    = P_IDLE;
    int who      = 0;
    int elapsed  = 0;
    int buzzLeft = 0;
    bit hist [9][HL];
    bit lvl  [9];
    bit prs  [9];

    competition_ctrl #(
        .DB_CYCLES  (DB),
        .TICK_CYCLES(TICK),
        .BUZZ_CYCLES(BUZZ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_btn (start_btn),
        .player_btn(player_btn),
        .view      (view),
        .state     (state),
        .led       (led),
        .buzzer    (buzzer)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One model step per clock edge: the round reacts to the presses seen on the
    // previous edge, then the debounced levels advance with this edge's pin sample.
    // A level flips once the DB+1 samples taken 2..DB+2 edges ago all disagree with it.
    task automatic modelStep();
        bit [8:0] pins;
        int       first;
        bit       flip;
        bit       newLevel;
        pins = {start_btn, player_btn};
        if (!rst) begin
            phase    = P_IDLE;
            who      = 0;
            elapsed  = 0;
            buzzLeft = 0;
            for (int b = 0; b < 9; b++) begin
                for (int k = 0; k < HL; k++) hist[b][k] = 1'b0;
                lvl[b] = 1'b0;
                prs[b] = 1'b0;
            end
            return;
        end
        first = -1;
        for (int i = 7; i >= 0; i--) if (prs[i]) first = i;
        case (phase)
            P_IDLE: begin
                if (first >= 0) begin
                    phase = P_FOUL; who = first; buzzLeft = BUZZ;
                end else if (prs[8]) begin
                    phase = P_ARMED; elapsed = 0;
                end
            end
            P_ARMED: begin
                if (first >= 0) begin
                    phase = P_WIN; who = first; buzzLeft = BUZZ;
                end else begin
                    elapsed++;
                    if (elapsed == 10 * TICK) phase = P_TIMEOUT;
                end
            end
            P_WIN, P_FOUL: begin
                if (prs[8]) begin
                    phase = P_IDLE; buzzLeft = 0;
                end else if (buzzLeft > 0) begin
                    buzzLeft--;
                end
            end
            P_TIMEOUT: begin
                if (prs[8]) phase = P_IDLE;
            end
            default: phase = P_IDLE;
        endcase
        for (int b = 0; b < 9; b++) begin
            for (int k = HL - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = pins[b];
            flip = 1'b1;
            for (int k = 2; k <= DB + 2; k++) if (hist[b][k] == lvl[b]) flip = 1'b0;
            newLevel = flip ? !lvl[b] : lvl[b];
            prs[b]   = newLevel && !lvl[b];
            lvl[b]   = newLevel;
        end
    endtask

    function automatic logic [31:0] expState();
        if (phase == P_WIN || phase == P_FOUL) return 32'(who + 1);
        if (phase == P_ARMED) return 32'(9 - elapsed / TICK);
        return 32'd0;
    endfunction

    function automatic logic [31:0] expLed();
        if (phase == P_WIN || phase == P_FOUL) return 32'd1 << who;
        return 32'd0;
    endfunction

    function automatic logic [31:0] expBuzzer();
        return ((phase == P_WIN || phase == P_FOUL) && buzzLeft > 0) ? 32'd1 : 32'd0;
    endfunction

    // Hold the given pin levels for n cycles, comparing every output each cycle.
    task automatic applyStimulus(input logic r, input logic s, input logic [7:0] p, input int n);
        for (int c = 0; c < n; c++) begin
            rst        = r;
            start_btn  = s;
            player_btn = p;
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkOutput("view",   32'(view),   32'(phase));
            checkOutput("state",  32'(state),  expState());
            checkOutput("led",    32'(led),    expLed());
            checkOutput("buzzer", 32'(buzzer), expBuzzer());
            if (buzzer) buzzCount++;
        end
    endtask

    initial begin
        int segs;
        logic s;
        logic [7:0] p;
        int len;

        rst = 1'b0; start_btn = 1'b1; player_btn = 8'hFF;

        // Reset with everything held, then the held player 1 fouls once debounced.
        applyStimulus(1'b0, 1'b1, 8'hFF, 2);
        checkOutput("rstView", 32'(view), 32'd0);
        checkOutput("rstState", 32'(state), 32'd0);
        checkOutput("rstLed", 32'(led), 32'd0);
        checkOutput("rstBuzzer", 32'(buzzer), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 7);
        checkOutput("heldIdle", 32'(view), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1);
        checkOutput("heldFoulView", 32'(view), 32'd3);
        checkOutput("heldFoulState", 32'(state), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 12);
        applyStimulus(1'b1, 1'b1, 8'h00, 10);
        applyStimulus(1'b1, 1'b0, 8'h00, 10);
        checkOutput("backIdle", 32'(view), 32'd0);

        // Arm, then player 5 wins with an 8-cycle buzz.
        applyStimulus(1'b1, 1'b1, 8'h00, 7);
        checkOutput("armEarly", 32'(view), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h00, 1);
        checkOutput("armView", 32'(view), 32'd2);
        checkOutput("armState", 32'(state), 32'd9);
        applyStimulus(1'b1, 1'b1, 8'h00, 2);
        applyStimulus(1'b1, 1'b0, 8'h00, 10);
        buzzCount = 0;
        applyStimulus(1'b1, 1'b0, 8'h10, 7);
        checkOutput("winEarly", 32'(view), 32'd2);
        applyStimulus(1'b1, 1'b0, 8'h10, 1);
        checkOutput("winView", 32'(view), 32'd1);
        checkOutput("winState", 32'(state), 32'd5);
        checkOutput("winLed", 32'(led), 32'h10);
        applyStimulus(1'b1, 1'b0, 8'h10, 4);
        applyStimulus(1'b1, 1'b0, 8'h00, 12);
        checkOutput("buzzLen", 32'(buzzCount), 32'd8);
        applyStimulus(1'b1, 1'b1, 8'h00, 8);
        applyStimulus(1'b1, 1'b0, 8'h00, 6);
        checkOutput("winToIdle", 32'(view), 32'd0);

        // Simultaneous presses: lowest index (player 3) wins.
        applyStimulus(1'b1, 1'b1, 8'h00, 8);
        applyStimulus(1'b1, 1'b0, 8'h00, 4);
        applyStimulus(1'b1, 1'b0, 8'hA4, 10);
        checkOutput("simState", 32'(state), 32'd3);
        checkOutput("simLed", 32'(led), 32'h04);
        applyStimulus(1'b1, 1'b0, 8'h00, 8);
        applyStimulus(1'b1, 1'b1, 8'h00, 8);
        applyStimulus(1'b1, 1'b0, 8'h00, 6);

        // Full countdown: entry on the 8th start cycle, timeout 160 cycles later.
        applyStimulus(1'b1, 1'b1, 8'h00, 8);
        applyStimulus(1'b1, 1'b0, 8'h00, 100);
        checkOutput("cdState", 32'(state), 32'd3);
        applyStimulus(1'b1, 1'b0, 8'h00, 59);
        checkOutput("cdLastView", 32'(view), 32'd2);
        checkOutput("cdLastState", 32'(state), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1);
        checkOutput("toView", 32'(view), 32'd4);
        applyStimulus(1'b1, 1'b1, 8'h00, 8);
        applyStimulus(1'b1, 1'b0, 8'h00, 6);
        checkOutput("toIdle", 32'(view), 32'd0);

        // Bouncing player 2 is rejected; a steady press fouls.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h02, 3);
            applyStimulus(1'b1, 1'b0, 8'h00, 3);
        end
        checkOutput("bounceIdle", 32'(view), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h02, 12);
        checkOutput("foulView", 32'(view), 32'd3);
        checkOutput("foulState", 32'(state), 32'd2);
        checkOutput("foulLed", 32'(led), 32'h02);

        // Player 7 pressed during FOUL (ignored) and held through arming: no win until re-pressed.
        applyStimulus(1'b1, 1'b0, 8'h40, 10);
        applyStimulus(1'b1, 1'b1, 8'h40, 8);
        applyStimulus(1'b1, 1'b0, 8'h40, 6);
        checkOutput("heldP7Idle", 32'(view), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h40, 8);
        applyStimulus(1'b1, 1'b0, 8'h40, 20);
        checkOutput("heldNoWin", 32'(view), 32'd2);
        applyStimulus(1'b1, 1'b0, 8'h00, 8);
        applyStimulus(1'b1, 1'b0, 8'h40, 10);
        checkOutput("repressView", 32'(view), 32'd1);
        checkOutput("repressState", 32'(state), 32'd7);
        applyStimulus(1'b1, 1'b0, 8'h00, 6);
        applyStimulus(1'b1, 1'b1, 8'h00, 8);
        applyStimulus(1'b1, 1'b0, 8'h00, 6);

        // Press event lands on the expiry cycle: win beats timeout.
        applyStimulus(1'b1, 1'b1, 8'h00, 8);
        applyStimulus(1'b1, 1'b0, 8'h00, 152);
        applyStimulus(1'b1, 1'b0, 8'h04, 7);
        checkOutput("collPreView", 32'(view), 32'd2);
        applyStimulus(1'b1, 1'b0, 8'h04, 1);
        checkOutput("collView", 32'(view), 32'd1);
        checkOutput("collState", 32'(state), 32'd3);
        checkOutput("collBuzzer", 32'(buzzer), 32'd1);

        // Reset in the middle of the buzz.
        applyStimulus(1'b0, 1'b0, 8'h04, 1);
        checkOutput("midRstView", 32'(view), 32'd0);
        checkOutput("midRstState", 32'(state), 32'd0);
        checkOutput("midRstLed", 32'(led), 32'd0);
        checkOutput("midRstBuzzer", 32'(buzzer), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h04, 12);
        applyStimulus(1'b1, 1'b0, 8'h00, 10);

        // Random activity with occasional resets and long quiet stretches.
        for (segs = 0; segs < 180; segs++) begin
            if ($urandom_range(0, 40) == 0) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 2));
            end else if ($urandom_range(0, 25) == 0) begin
                applyStimulus(1'b1, 1'b0, 8'h00, 170);
            end else begin
                s = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 5))
                    0:       p = 8'($urandom);
                    1, 2:    p = 8'd1 << $urandom_range(0, 7);
                    default: p = 8'h00;
                endcase
                len = $urandom_range(1, 14);
                applyStimulus(1'b1, s, p, len);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/competition_ctrl.md
# competition_ctrl

Round controller for the quiz-competition system, the producer of the `view`/`state` pair consumed by the competition display block. It debounces the host start button and eight player buttons, then runs the round state machine: idle, armed with a countdown, winner, foul, or timeout. It drives the display code pair, a one-hot player LED bank and a buzzer pulse.

## Interface
- `DB_CYCLES`, default 1_000_000 — consecutive stable cycles required before a debounced level changes.
- `TICK_CYCLES`, default 100_000_000 — cycles per countdown step (one second at 100 MHz).
- `BUZZ_CYCLES`, default 20_000_000 — buzzer pulse length in cycles.
- `clk` input 1 — system clock; the only clock.
- `rst` input 1 — reset, synchronous, active-low.
- `start_btn` input 1 — host button, active-high, asynchronous to `clk`.
- `player_btn` input 8 — player buttons, active-high, asynchronous; bit i is player i+1.
- `view` output 3 — phase code: 0 idle, 1 winner, 2 armed, 3 foul, 4 timeout.
- `state` output 4 — value shown: player number 1–8 in views 1 and 3, seconds remaining 9–0 in view 2, 0 otherwise.
- `led` output 8 — one-hot LED for the winning or fouling player; 0 otherwise.
- `buzzer` output 1 — high for BUZZ_CYCLES on entry to WIN or FOUL.

## Operation
- **Input conditioning (per button, 9 total)**
  - 2-flop synchronizer, then a debouncer.
  - The debounced level takes the synchronized value only after it has differed from the current debounced level for DB_CYCLES consecutive cycles.
  - Any mismatch-free cycle clears that counter.
  - A rising-edge detector on the debounced level produces a one-cycle `press` pulse.
  - Only presses are events; holding a button never re-triggers.
- **FSM states**: IDLE, ARMED, WIN, FOUL, TIMEOUT.
- **IDLE** (view 0, state 0, led 0)
  - Any player press → FOUL, with the lowest-index pressed player.
  - Otherwise a start press → ARMED.
  - Player press takes priority over start press in the same cycle.
- **ARMED** (view 2)
  - Entry: state=9, tick counter=0.
  - Tick counter counts to TICK_CYCLES-1, then wraps.
  - On wrap: if state>0, decrement state; if state==0, → TIMEOUT.
  - ARMED therefore lasts exactly 10×TICK_CYCLES cycles without presses.
  - Any player press → WIN with the lowest-index pressed player; this takes priority over a same-cycle expiry.
  - Start press in ARMED is ignored.
- **WIN** (view 1) and **FOUL** (view 3)
  - state = player index+1; led = 1<<index.
  - buzzer counter loads BUZZ_CYCLES on entry; buzzer high while the counter is nonzero.
  - Further player presses are ignored.
  - Start press → IDLE; led clears; buzzer stops immediately.
- **TIMEOUT** (view 4, state 0, led 0, buzzer 0)
  - Start press → IDLE; player presses ignored.
- Buttons already held on entry to ARMED produce no press, so they cannot win.
- **Widths**
  - Debounce, tick and buzzer counters are sized by `$clog2` of their parameter; no overflow is permitted.
  - `state` never exceeds 9.

## Timing
- All outputs are registered.
- **Reset values**: view=0, state=0, led=0, buzzer=0, FSM=IDLE; all counters, synchronizer flops and debounced levels = 0.
- **Reset mid-round** (rst low on any edge): the next cycle shows the full reset values, regardless of held buttons.
- After reset, a held button needs DB_CYCLES stable cycles to register as a press.
- **Press latency**
  - A pin level change sampled at edge N raises the debounced level at edge N+2+DB_CYCLES.
  - `press` fires that same cycle.
  - view/state/led update at edge N+3+DB_CYCLES.
  - buzzer rises on the same edge as view.
- **Glitch rejection**: a pulse shorter than DB_CYCLES cycles after synchronization produces no event.
- **Countdown timing**: the first decrement (9→8) occurs TICK_CYCLES cycles after the ARMED entry edge; TIMEOUT is entered 10×TICK_CYCLES cycles after entry.
- **Buzzer**: high for exactly BUZZ_CYCLES cycles unless start-cleared earlier.

## Test plan
All scenarios use DB_CYCLES=4, TICK_CYCLES=16, BUZZ_CYCLES=8.
- **Reset**: rst low 2 cycles with all buttons high → view=0, state=0, led=0, buzzer=0; still idle 6 cycles after release until a debounced press occurs, then view=3 (foul, player 1, because bit 0 held).
- **Arm and win**
  - Pulse start (held 10 cycles) → view=2, state=9 exactly 7 cycles after the pin rose.
  - Press player_btn[4] → view=1, state=5, led=8'h10, buzzer high 8 cycles.
  - Start → view=0.
- **Simultaneous presses in ARMED**: player_btn=8'b1010_0100 on one edge → state=3, led=8'h04.
- **Countdown and timeout**: arm, no presses → state steps 9..0 every 16 cycles; view=4, state=0 at 160 cycles after entry; start → view=0.
- **Bounce and early press**
  - Player 2 pin toggles with 3-cycle pulses in IDLE → no change.
  - Steady press of player 2 → view=3, state=2, led=8'h02.
  - Player 7 held from IDLE through arming → stays view=2 until it is released and re-pressed.
- **Expiry collision and mid-round reset**
  - A press whose event lands on the expiry cycle when state=0 → WIN, not TIMEOUT.
  - rst low during WIN with buzzer high → all outputs 0 on the next edge.
